counter_cmd_sequencer: RTL and testbench
========================================

COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  upstream command valid.
REQ-005 Port: cmd_ready  output  1  FIFO can accept a command.
REQ-006 Port: cmd_mode  input  2  00 inc, 01 dec, 10 add value, 11 subtract value.
REQ-007 Port: cmd_value  input  4  operand for modes 10/11.
REQ-008 Port: cmd_repeat  input  4  issue count minus one (0..15 gives 1..16 issues).
REQ-009 Port: overflow  input  1  carry/borrow flag from the downstream counter, combinational on the current operation.
REQ-010 Port: clear_halt  input  1  leaves HALT state.
REQ-011 Port: enable  output  1  counter step enable.
REQ-012 Port: mode  output  2  counter operation mode.
REQ-013 Port: input_value  output  4  counter operand.
REQ-014 Port: busy  output  1  state is not IDLE.
REQ-015 Port: fifo_level  output  clog2(FIFO_DEPTH)+1  occupied entries (3 bits at default).
REQ-016 Port: done  output  1  one-cycle pulse, one command finished.
REQ-017 Port: halted  output  1  state is HALT.

Function
REQ-018 The FIFO SHALL store {cmd_mode, cmd_value, cmd_repeat} in order; a push occurs when cmd_valid and cmd_ready are both high at a clock edge.
REQ-019 cmd_ready SHALL equal (fifo_level != FIFO_DEPTH), derived only from registered state; a full FIFO SHALL NOT accept a push in a cycle where it also pops.
REQ-020 The state machine SHALL have states IDLE, ISSUE and HALT.
REQ-021 In IDLE with fifo_level != 0, the head command SHALL be popped into working registers (mode, value, remaining = repeat), with a transition to ISSUE.
REQ-022 In ISSUE, enable SHALL be 1, and mode/input_value SHALL equal the working registers; in IDLE and HALT, enable SHALL be 0.
REQ-023 In ISSUE with remaining != 0, remaining SHALL decrement by 1 each cycle.
REQ-024 In ISSUE with remaining == 0 (last issue), done SHALL pulse high in the following cycle.
  - If the FIFO is non-empty, the next command SHALL be popped and loaded in the same edge, staying in ISSUE with no bubble cycle.
  - Otherwise, the state SHALL go to IDLE.
REQ-025 Latency: a command pushed into an empty idle block at edge k SHALL have enable high in the cycle following edge k+1.
REQ-026 A command SHALL cause exactly cmd_repeat+1 enable cycles, unless cut short by REQ-032.
REQ-027 Simultaneous push and pop SHALL leave fifo_level unchanged; a push into an empty FIFO in the same edge as an IDLE check SHALL be seen on the next cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 mode and input_value SHALL hold their last values while enable is 0.

Reset
REQ-030 Reset SHALL take effect at the next rising clk edge, including mid-command and from HALT. After that edge:
  - state = IDLE and the FIFO is empty (fifo_level = 0);
  - enable = 0, mode = 00, input_value = 0000;
  - done = 0, halted = 0, busy = 0, cmd_ready = 1.
REQ-031 A push attempted in the reset cycle SHALL be discarded.

Configuration
REQ-032 With macro CMDSEQ_OVF_HALT_EN defined, overflow = 1 in any ISSUE cycle SHALL cause the following:
  - The state SHALL go to HALT at the next edge.
  - The current command's remaining issues SHALL be discarded.
  - done SHALL pulse only if that cycle was the last issue.
  - FIFO contents SHALL be retained.
  - clear_halt in HALT SHALL return the state to IDLE at the next edge.
REQ-033 Without CMDSEQ_OVF_HALT_EN, overflow and clear_halt SHALL be ignored, HALT SHALL be unreachable, and halted SHALL be tied 0.

Verification
REQ-034 Reset, then push {10, 0011, 0010} -> 3 consecutive enable cycles with mode=10, input_value=0011; done pulses once; then IDLE.
REQ-035 Push 4 commands back-to-back with repeat=0 -> cmd_ready=0 after the fourth push while fifo_level=4; 4 contiguous enable cycles with no bubble; 4 done pulses.
REQ-036 Push while fifo_level=4 and a pop occurs in the same cycle -> push rejected; fifo_level=3 afterwards.
REQ-037 Assert reset during the second issue of a repeat=5 command with 2 entries queued -> next cycle enable=0, fifo_level=0, busy=0.
REQ-038 With CMDSEQ_OVF_HALT_EN, overflow=1 on the first issue of a repeat=3 command -> halted=1, no done, enable=0 until clear_halt; the queued command issues after clear_halt.
REQ-039 Without the macro, the same stimulus as REQ-038 -> all 4 issues occur, halted stays 0.

Source files
------------

// File: rtl/counter_cmd_sequencer_if.sv
// Command channel between an upstream producer and the counter command sequencer FIFO.
interface counter_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_value;
  logic [3:0] cmd_repeat;

  modport master (
    output cmd_valid, cmd_mode, cmd_value, cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_value, cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_sequencer.sv
// Queues counter commands and issues each one repeat+1 times to a downstream counter.
// Define CMDSEQ_OVF_HALT_EN to halt on counter overflow until clear_halt.
module counter_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  counter_cmd_sequencer_if.slave        cmd,
  input  logic                          overflow,
  input  logic                          clear_halt,
  output logic                          enable,
  output logic [1:0]                    mode,
  output logic [3:0]                    input_value,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          done,
  output logic                          halted
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HALT} seqState_t;

  seqState_t     state_q, state_d;
  logic [9:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [LW-1:0] level_q, level_d;
  logic [9:0]    headEntry;
  logic          push, pop;
  logic [1:0]    workMode_q, workMode_d;
  logic [3:0]    workValue_q, workValue_d;
  logic [3:0]    remain_q, remain_d;
  logic          done_q, done_d;
  logic          ovfHalt, haltRelease;

`ifdef CMDSEQ_OVF_HALT_EN
  assign ovfHalt     = overflow;
  assign haltRelease = clear_halt;
  assign halted      = (state_q == HALT);
`else
  logic unusedHaltInputs;
  assign unusedHaltInputs = overflow ^ clear_halt;
  assign ovfHalt          = 1'b0;
  assign haltRelease      = 1'b0;
  assign halted           = 1'b0;
`endif

  // Ready comes only from registered level, so a full FIFO never takes a push even while popping
  assign cmd.cmd_ready = (level_q != LW'(FIFO_DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign headEntry     = fifoMem[rdPtr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= {cmd.cmd_mode, cmd.cmd_value, cmd.cmd_repeat};
    end
  end

  // On the last issue the next command is loaded in the same edge so issues run without a bubble
  always_comb begin
    state_d     = state_q;
    workMode_d  = workMode_q;
    workValue_d = workValue_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop         = 1'b1;
          workMode_d  = headEntry[9:8];
          workValue_d = headEntry[7:4];
          remain_d    = headEntry[3:0];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (ovfHalt) begin
          done_d  = (remain_q == '0);
          state_d = HALT;
        end else if (remain_q != '0) begin
          remain_d = remain_q - 1'b1;
        end else begin
          done_d = 1'b1;
          if (level_q != '0) begin
            pop         = 1'b1;
            workMode_d  = headEntry[9:8];
            workValue_d = headEntry[7:4];
            remain_d    = headEntry[3:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        if (haltRelease) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      workMode_q  <= '0;
      workValue_q <= '0;
      remain_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      workMode_q  <= workMode_d;
      workValue_q <= workValue_d;
      remain_q    <= remain_d;
      done_q      <= done_d;
    end
  end

  assign enable      = (state_q == ISSUE);
  assign mode        = workMode_q;
  assign input_value = workValue_q;
  assign busy        = (state_q != IDLE);
  assign fifo_level  = level_q;
  assign done        = done_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer; expected enable/done patterns are hand-computed per cycle.
module tb_counter_cmd_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       overflow;
  logic       clearHalt;
  logic       enable;
  logic [1:0] mode;
  logic [3:0] inputValue;
  logic       busy;
  logic [2:0] fifoLevel;
  logic       done;
  logic       halted;

  logic [31:0] enBits, doneBits, haltBits;
  logic [63:0] opsLog;
  int checks   = 0;
  int failures = 0;

  counter_cmd_sequencer_if cmdIf ();

  counter_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmdIf),
    .overflow    (overflow),
    .clear_halt  (clearHalt),
    .enable      (enable),
    .mode        (mode),
    .input_value (inputValue),
    .busy        (busy),
    .fifo_level  (fifoLevel),
    .done        (done),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] m, input logic [3:0] v, input logic [3:0] r);
    cmdIf.cmd_valid  = valid;
    cmdIf.cmd_mode   = m;
    cmdIf.cmd_value  = v;
    cmdIf.cmd_repeat = r;
  endtask

  // Bit i of each vector is the output in the i-th cycle; opsLog packs {mode,value} of each issue, oldest first
  task automatic observeWindow(input int n);
    enBits   = '0;
    doneBits = '0;
    haltBits = '0;
    opsLog   = '0;
    for (int i = 0; i < n; i++) begin
      enBits[i]   = enable;
      doneBits[i] = done;
      haltBits[i] = halted;
      if (enable) opsLog = {opsLog[57:0], mode, inputValue};
      stepClk();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    overflow  = 1'b0;
    clearHalt = 1'b0;
    reset     = 1'b1;
    applyStimulus(1'b1, 2'd2, 4'd7, 4'd1);
    stepClk();
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_mode", mode, 0);
    checkOutput("rst_value", inputValue, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmdIf.cmd_ready, 1);
    checkOutput("rst_level", fifoLevel, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0);
    stepClk();
    checkOutput("rst_push_dropped", fifoLevel, 0);
    checkOutput("rst_idle_busy", busy, 0);

    // Single add command, three issues
    applyStimulus(1'b1, 2'd2, 4'd3, 4'd2);
    stepClk();
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0);
    checkOutput("t1_level_after_push", fifoLevel, 1);
    checkOutput("t1_no_enable_yet", enable, 0);
    observeWindow(8);
    checkOutput("t1_enable_pattern", enBits, 32'h0000_000E);
    checkOutput("t1_done_pattern", doneBits, 32'h0000_0010);
    checkOutput("t1_ops", opsLog, 64'h238E3);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_mode_hold", mode, 2);
    checkOutput("t1_value_hold", inputValue, 3);

    // Long command keeps the sequencer busy while four short ones fill the FIFO
    applyStimulus(1'b1, 2'd1, 4'd6, 4'd15);
    stepClk();
    applyStimulus(1'b1, 2'd0, 4'd1, 4'd0);
    stepClk();
    applyStimulus(1'b1, 2'd1, 4'd2, 4'd0);
    stepClk();
    applyStimulus(1'b1, 2'd2, 4'd5, 4'd0);
    stepClk();
    applyStimulus(1'b1, 2'd3, 4'd9, 4'd0);
    stepClk();
    checkOutput("t2_full_level", fifoLevel, 4);
    checkOutput("t2_full_ready", cmdIf.cmd_ready, 0);
    checkOutput("t2_long_enable", enable, 1);
    checkOutput("t2_long_mode", mode, 1);
    checkOutput("t2_long_value", inputValue, 6);
    applyStimulus(1'b1, 2'd3, 4'd15, 4'd7);
    repeat (12) stepClk();
    checkOutput("t2_still_full", fifoLevel, 4);
    checkOutput("t2_still_not_ready", cmdIf.cmd_ready, 0);
    stepClk();
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0);
    checkOutput("t2_push_rejected_level", fifoLevel, 3);
    observeWindow(8);
    checkOutput("t2_enable_pattern", enBits, 32'h0000_000F);
    checkOutput("t2_done_pattern", doneBits, 32'h0000_001F);
    checkOutput("t2_ops_order", opsLog, 64'h052979);
    checkOutput("t2_drained_level", fifoLevel, 0);
    checkOutput("t2_drained_busy", busy, 0);

    // Reset during the second issue with two commands still queued
    applyStimulus(1'b1, 2'd0, 4'd4, 4'd5);
    stepClk();
    applyStimulus(1'b1, 2'd1, 4'd1, 4'd0);
    stepClk();
    applyStimulus(1'b1, 2'd2, 4'd2, 4'd0);
    stepClk();
    checkOutput("t3_pre_reset_enable", enable, 1);
    checkOutput("t3_pre_reset_level", fifoLevel, 2);
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0);
    reset = 1'b1;
    stepClk();
    reset = 1'b0;
    checkOutput("t3_reset_enable", enable, 0);
    checkOutput("t3_reset_level", fifoLevel, 0);
    checkOutput("t3_reset_busy", busy, 0);
    checkOutput("t3_reset_mode", mode, 0);
    checkOutput("t3_reset_ready", cmdIf.cmd_ready, 1);
    observeWindow(4);
    checkOutput("t3_nothing_issues", enBits, 32'h0);
    checkOutput("t3_no_done", doneBits, 32'h0);

    // Overflow on the first issue of a four-issue command, one more command queued
    applyStimulus(1'b1, 2'd0, 4'd2, 4'd3);
    stepClk();
    applyStimulus(1'b1, 2'd1, 4'd4, 4'd0);
    stepClk();
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0);
    checkOutput("t4_first_issue", enable, 1);
    checkOutput("t4_first_value", inputValue, 2);
    overflow  = 1'b1;
`ifdef CMDSEQ_OVF_HALT_EN
    stepClk();
    overflow = 1'b0;
    checkOutput("t4_halted", halted, 1);
    checkOutput("t4_halt_enable", enable, 0);
    checkOutput("t4_halt_no_done", done, 0);
    checkOutput("t4_halt_busy", busy, 1);
    checkOutput("t4_halt_keeps_fifo", fifoLevel, 1);
    observeWindow(3);
    checkOutput("t4_halt_hold_enable", enBits, 32'h0);
    checkOutput("t4_halt_hold_flag", haltBits, 32'h7);
    clearHalt = 1'b1;
    stepClk();
    clearHalt = 1'b0;
    checkOutput("t4_released", halted, 0);
    observeWindow(5);
    checkOutput("t4_after_enable", enBits, 32'h2);
    checkOutput("t4_after_done", doneBits, 32'h4);
    checkOutput("t4_after_ops", opsLog, 64'h14);
`else
    clearHalt = 1'b1;
    stepClk();
    overflow  = 1'b0;
    clearHalt = 1'b0;
    checkOutput("t4_not_halted", halted, 0);
    checkOutput("t4_keeps_issuing", enable, 1);
    checkOutput("t4_no_early_done", done, 0);
    observeWindow(8);
    checkOutput("t4_enable_pattern", enBits, 32'hF);
    checkOutput("t4_done_pattern", doneBits, 32'h18);
    checkOutput("t4_ops", opsLog, 64'h082094);
    checkOutput("t4_halt_never", haltBits, 32'h0);
`endif
    checkOutput("t4_final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
